// File: rtl/edge_det_pkg.sv
// Shared encodings for the multi-channel edge detector.
// Mode select values (per channel, 2 bits) and debounce FSM state encoding.
// No ports; imported by edge_det_chan and edge_det_multi.
package edge_det_pkg;

  // Per-channel edge select: bit0 enables rising, bit1 enables falling.
  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Debounce FSM states.
  localparam logic DB_STABLE = 1'b0;
  localparam logic DB_CHECK  = 1'b1;

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser chain, debounce FSM with counter, registered edge tick.
// Latency: tick and level_db change SYNC_STAGES+DEB_LEN posedges after the first edge sampling a new level.
// Ports: clk, rst (sync, active-high), level (async in), mode[1:0], level_db (out), tick (out); no backpressure.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_LEN     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  input  logic [1:0] mode,
  output logic       level_db,
  output logic       tick
);

  localparam int              CW       = $clog2(DEB_LEN + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_i;
  logic                   differ;
  logic                   flip;
  logic                   state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_db_q, level_db_d;
  logic                   tick_q, tick_d;

  // Shift chain; the oldest stage is the synchronised sample.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], level};
  end

  assign sync_i = sync_q[SYNC_STAGES-1];
  assign differ = sync_i ^ level_db_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DB_STABLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. With DEB_LEN==1 the flip happens straight from STABLE,
  // so CHECK is never entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DB_STABLE: if (differ && (DEB_LEN > 1)) state_d = DB_CHECK;
      DB_CHECK:  if (!differ || (cnt_q == CNT_LAST)) state_d = DB_STABLE;
      default:   state_d = DB_STABLE;
    endcase
  end

  // FSM outputs: counter, level flip and tick qualification.
  always_comb begin
    cnt_d = '0;
    flip  = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (differ) begin
          if (DEB_LEN == 1) flip  = 1'b1;
          else              cnt_d = CNT_ONE;
        end
      end
      DB_CHECK: begin
        // A bounce (differ low) falls through with cnt_d = 0.
        if (differ) begin
          if (cnt_q == CNT_LAST) flip  = 1'b1;
          else                   cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase
    level_db_d = level_db_q ^ flip;
    // Current level_db tells the direction: 0 means this flip is a rise.
    tick_d = flip & (|(mode & (level_db_q ? EDGE_FALL : EDGE_RISE)));
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level_db_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      level_db_q <= level_db_d;
      tick_q     <= tick_d;
    end
  end

  assign level_db = level_db_q;
  assign tick     = tick_q;

endmodule

// File: rtl/edge_det_multi.sv
// N_CH independent sync/debounce/edge-tick channels with optional sticky status and irq.
// Latency: tick SYNC_STAGES+DEB_LEN posedges after a new level is first sampled; status one cycle after tick.
// Ports: clk, rst (sync, active-high), level, mode[2*N_CH], level_db, tick, status, clr (W1C), irq.
// Optional status/irq logic is built only when EDGE_DET_STATUS_EN is defined; otherwise status/irq are 0.
module edge_det_multi
  import edge_det_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_LEN     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   level,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   level_db,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   status,
  input  logic [N_CH-1:0]   clr,
  output logic              irq
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_LEN     (DEB_LEN)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .level    (level[i]),
      .mode     (mode[2*i +: 2]),
      .level_db (level_db[i]),
      .tick     (tick[i])
    );
  end

`ifdef EDGE_DET_STATUS_EN
  logic [N_CH-1:0] status_q, status_d;

  // Set has priority over clear when both land in the same cycle.
  always_comb begin
    status_d = tick | (status_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status = status_q;
  assign irq    = |status_q;
`else
  logic unused_clr;
  assign unused_clr = ^clr;
  assign status     = '0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_edge_det_multi.sv
module tb_edge_det_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] level;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] level_db;
  logic [3:0] tick;
  logic [3:0] status;
  logic       irq;

  int n_cmp = 0;
  int n_err = 0;

  edge_det_multi #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .DEB_LEN     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .level    (level),
    .mode     (mode),
    .level_db (level_db),
    .tick     (tick),
    .status   (status),
    .clr      (clr),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run ncyc cycles; tick must equal exp_tick on cycle 'hit' and 0 elsewhere.
  task automatic watch(input string tag, input int ncyc, input int hit, input logic [3:0] exp_tick);
    for (int k = 1; k <= ncyc; k++) begin
      cyc();
      check(tag, 32'(tick), (k == hit) ? 32'(exp_tick) : 32'd0);
    end
  endtask

  initial begin
    int cnt;
    logic [1:0] mode_tab [4];
    int         exp_cnt  [4];
    mode_tab[0] = 2'b00; exp_cnt[0] = 0;
    mode_tab[1] = 2'b01; exp_cnt[1] = 2;
    mode_tab[2] = 2'b10; exp_cnt[2] = 2;
    mode_tab[3] = 2'b11; exp_cnt[3] = 4;

    rst = 1'b1; level = '0; mode = '0; clr = '0;

    // Reset state
    repeat (3) cyc();
    check("rst_level_db", 32'(level_db), 32'd0);
    check("rst_tick",     32'(tick),     32'd0);
    check("rst_status",   32'(status),   32'd0);
    check("rst_irq",      32'(irq),      32'd0);

    // Latency: rise on ch0 ticks on the 5th posedge counting the sampling one
    rst = 1'b0; level = 4'b0001; mode = 8'b0000_0001;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("lat_tick",     32'(tick),     (k == 5) ? 32'd1 : 32'd0);
      check("lat_level_db", 32'(level_db), (k >= 5) ? 32'd1 : 32'd0);
      check("lat_status",   32'(status),   32'd0);
    end

    // Bounce rejection on ch1: 2-high / 1-low pulses never reach DEB_LEN
    mode = 8'b0000_1101;
    for (int p = 0; p < 4; p++) begin
      level[1] = 1'b1; cyc(); check("bnc_tick", 32'(tick[1]), 32'd0);
      cyc();                  check("bnc_tick", 32'(tick[1]), 32'd0);
      level[1] = 1'b0; cyc(); check("bnc_tick", 32'(tick[1]), 32'd0);
    end
    repeat (4) begin cyc(); check("bnc_tick", 32'(tick[1]), 32'd0); end
    check("bnc_level_db", 32'(level_db[1]), 32'd0);
    level[1] = 1'b1;
    cnt = 0;
    repeat (10) begin cyc(); cnt += int'(tick[1]); end
    check("bnc_hold_cnt",  cnt, 1);
    check("bnc_hold_ldb",  32'(level_db[1]), 32'd1);
    level[1] = 1'b0;
    repeat (10) cyc();

    // Mode filtering on ch2: 4 toggles, 10 cycles apart, per mode
    for (int m = 0; m < 4; m++) begin
      mode[5:4] = mode_tab[m];
      cnt = 0;
      for (int t = 0; t < 4; t++) begin
        level[2] = ~level[2];
        repeat (10) begin cyc(); cnt += int'(tick[2]); end
        check("mode_level_db", 32'(level_db[2]), 32'(level[2]));
      end
      check("mode_tick_cnt", cnt, exp_cnt[m]);
    end

    // Simultaneous channels
    mode = 8'hFF; level = 4'b0000;
    repeat (10) cyc();
    check("sim_pre_ldb", 32'(level_db), 32'd0);
    level = 4'b1111;
    watch("sim_rise", 6, 5, 4'b1111);
    level = 4'b0110;
    watch("sim_fall", 6, 5, 4'b1001);
    check("sim_ldb", 32'(level_db), 32'(4'b0110));

    // Reset while ch0 is in CHECK with counter 2
    level = 4'b0111;
    repeat (4) cyc();
    check("mid_pre_tick", 32'(tick), 32'd0);
    rst = 1'b1;
    cyc();
    check("mid_rst_ldb",    32'(level_db), 32'd0);
    check("mid_rst_tick",   32'(tick),     32'd0);
    check("mid_rst_status", 32'(status),   32'd0);
    check("mid_rst_irq",    32'(irq),      32'd0);
    rst = 1'b0;
    watch("mid_relatch", 6, 5, 4'b0111);
    check("mid_ldb", 32'(level_db), 32'(4'b0111));

`ifdef EDGE_DET_STATUS_EN
    // Status: clear what the previous step set
    check("st_pre", 32'(status), 32'(4'b0111));
    clr = 4'b1111; cyc(); clr = '0;
    check("st_clr_all", 32'(status), 32'd0);
    check("st_clr_irq", 32'(irq),    32'd0);
    level[3] = 1'b1;
    watch("st_rise3", 5, 5, 4'b1000);
    cyc();
    check("st_set",     32'(status), 32'(4'b1000));
    check("st_set_irq", 32'(irq),    32'd1);
    level[3] = 1'b0;
    watch("st_fall3", 5, 5, 4'b1000);
    clr = 4'b1000; cyc(); clr = '0;
    check("st_set_wins", 32'(status), 32'(4'b1000));
    check("st_win_irq",  32'(irq),    32'd1);
    clr = 4'b1000; cyc(); clr = '0;
    check("st_clr",     32'(status), 32'd0);
    check("st_clr_irq", 32'(irq),    32'd0);
`else
    // Status disabled: outputs stay 0 and clr has no effect
    level[3] = 1'b1; clr = 4'b1111;
    watch("nost_rise3", 6, 5, 4'b1000);
    check("nost_status", 32'(status), 32'd0);
    check("nost_irq",    32'(irq),    32'd0);
    clr = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
